// File: rtl/lvds_tx_ser.sv
// rtl/lvds_tx_ser.sv - word-to-serial transmitter for one LVDS lane, LSB first,
// with idle-word fill on underflow and a saturating underflow counter.
module lvds_tx_ser #(
  parameter int               WIDTH     = 10,
  parameter logic [WIDTH-1:0] IDLE_WORD = 10'b1101010100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             inv,
  input  logic             force_idle,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_o,
  output logic             word_sync,
  output logic             busy,
  output logic [15:0]      unf_cnt,
  input  logic             unf_clr
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {S_OFF = 1'b0, S_RUN = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_bitcnt, w_bitcnt_nxt;
  logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
  logic             r_inv_q, w_inv_nxt;
  logic [15:0]      r_unf_cnt, w_unf_nxt;
  logic             w_at_last;
  logic             w_load;
  logic             w_underflow;

  assign w_at_last   = (r_bitcnt == LAST);
  assign w_load      = !rst && en && ((r_state == S_OFF) || w_at_last);
  assign w_underflow = w_load && !in_valid && !force_idle;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_OFF;
      r_bitcnt  <= '0;
      r_shreg   <= '0;
      r_inv_q   <= 1'b0;
      r_unf_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_shreg   <= w_shreg_nxt;
      r_inv_q   <= w_inv_nxt;
      r_unf_cnt <= w_unf_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_bitcnt_nxt = r_bitcnt;
    w_shreg_nxt  = r_shreg;
    w_inv_nxt    = r_inv_q;
    w_unf_nxt    = r_unf_cnt;
    if (w_load) begin
      w_state_nxt  = S_RUN;
      w_bitcnt_nxt = '0;
      w_inv_nxt    = inv;
      w_shreg_nxt  = (in_valid && !force_idle) ? in_data : IDLE_WORD;
    end else if (r_state == S_RUN) begin
      // en low at the last bit: finish the word, then drop the lane
      if (w_at_last) begin
        w_state_nxt = S_OFF;
      end else begin
        w_shreg_nxt  = r_shreg >> 1;
        w_bitcnt_nxt = r_bitcnt + CW'(1);
      end
    end
    if (unf_clr) begin
      w_unf_nxt = '0;
    end else if (w_underflow && (r_unf_cnt != 16'hFFFF)) begin
      w_unf_nxt = r_unf_cnt + 16'd1;
    end
  end

  // outputs are forced quiet while rst is held, even before the first reset edge
  assign in_ready  = w_load && !force_idle;
  assign busy      = !rst && (r_state == S_RUN);
  assign ser_o     = !rst && ((r_shreg[0] && (r_state == S_RUN)) ^ r_inv_q);
  assign word_sync = busy && (r_bitcnt == '0);
  assign unf_cnt   = r_unf_cnt;

endmodule

// File: tb/tb_lvds_tx_ser.sv
// tb/tb_lvds_tx_ser.sv - directed and randomized bench for lvds_tx_ser against a
// queue-based model of the outgoing bit stream.
module tb_lvds_tx_ser;

  localparam int         W    = 10;
  localparam logic [9:0] IDLE = 10'b1101010100;

  logic         clk = 1'b0;
  logic         rst, en, inv, force_idle, in_valid, unf_clr;
  logic [W-1:0] in_data;
  logic         in_ready, ser_o, word_sync, busy;
  logic [15:0]  unf_cnt;

  logic         s_rst, s_en, s_clr;
  logic         s_ready, s_ser, s_sync, s_busy;
  logic [15:0]  s_unf;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lvds_tx_ser #(.WIDTH(W), .IDLE_WORD(IDLE)) dut (
    .clk(clk), .rst(rst), .en(en), .inv(inv), .force_idle(force_idle),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ser_o(ser_o), .word_sync(word_sync), .busy(busy),
    .unf_cnt(unf_cnt), .unf_clr(unf_clr)
  );

  // one-bit words load every cycle, so the underflow counter can be driven to saturation quickly
  lvds_tx_ser #(.WIDTH(1), .IDLE_WORD(1'b0)) u_sat (
    .clk(clk), .rst(s_rst), .en(s_en), .inv(1'b0), .force_idle(1'b0),
    .in_data(1'b0), .in_valid(1'b0), .in_ready(s_ready),
    .ser_o(s_ser), .word_sync(s_sync), .busy(s_busy),
    .unf_cnt(s_unf), .unf_clr(s_clr)
  );

  // model: the bits still to appear on the lane, front = bit currently shown
  bit          m_q[$];
  logic        m_on  = 1'b0;
  logic        m_inv = 1'b0;
  logic [15:0] m_unf = 16'd0;
  logic        e_load, e_ready, e_busy, e_sync, e_ser;

  task automatic model_eval();
    e_load  = !rst && en && (!m_on || (m_q.size() == 1));
    e_ready = e_load && !force_idle;
    e_busy  = !rst && m_on;
    e_sync  = e_busy && (m_q.size() == W);
    e_ser   = 1'b0;
    if (!rst) begin
      if (m_on && (m_q.size() > 0)) e_ser = m_q[0];
      e_ser = e_ser ^ m_inv;
    end
  endtask

  task automatic model_update();
    logic [W-1:0] word;
    if (rst) begin
      m_on = 1'b0; m_inv = 1'b0; m_unf = 16'd0; m_q.delete();
    end else begin
      if (unf_clr) m_unf = 16'd0;
      else if (e_load && !in_valid && !force_idle && (m_unf != 16'hFFFF)) m_unf = m_unf + 16'd1;
      if (e_load) begin
        word = (in_valid && !force_idle) ? in_data : IDLE;
        m_q.delete();
        for (int i = 0; i < W; i++) m_q.push_back(word[i]);
        m_inv = inv;
        m_on  = 1'b1;
      end else if (m_on) begin
        if (m_q.size() == 1) m_on = 1'b0;
        else void'(m_q.pop_front());
      end
    end
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; in_valid = 1'b1; in_data = 10'h2AB; inv = 1'b1;
    #1;
    n_checks++; if ({ser_o, word_sync, busy, in_ready} !== 4'b0000) begin n_errors++; $display("FAIL reset_outs got %b exp 0000", {ser_o, word_sync, busy, in_ready}); end
    tick(); tick();
    #1;
    n_checks++; if ({ser_o, word_sync, busy, in_ready} !== 4'b0000) begin n_errors++; $display("FAIL reset_outs2 got %b exp 0000", {ser_o, word_sync, busy, in_ready}); end
    n_checks++; if (unf_cnt !== 16'd0) begin n_errors++; $display("FAIL reset_unf got %h exp 0000", unf_cnt); end
    rst = 1'b0; en = 1'b0; inv = 1'b0; s_rst = 1'b0;
    tick();
    #1;
    n_checks++; if ({ser_o, busy} !== 2'b00) begin n_errors++; $display("FAIL off_idle got %b exp 00", {ser_o, busy}); end
  endtask

  task automatic test_single_word();
    logic [9:0] w = 10'h155;
    en = 1'b1; in_valid = 1'b1; in_data = w; force_idle = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL single_ready got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < W; k++) begin
      if (k == W - 1) en = 1'b0;
      #1;
      n_checks++; if (ser_o !== w[k]) begin n_errors++; $display("FAIL single_bit%0d got %b exp %b", k, ser_o, w[k]); end
      n_checks++; if (word_sync !== (k == 0)) begin n_errors++; $display("FAIL single_sync%0d got %b exp %b", k, word_sync, k == 0); end
      tick();
    end
    #1;
    n_checks++; if ({busy, ser_o} !== 2'b00) begin n_errors++; $display("FAIL single_end got %b exp 00", {busy, ser_o}); end
  endtask

  task automatic test_back_to_back();
    en = 1'b1; in_valid = 1'b1; in_data = 10'h3FF;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready0 got %b exp 1", in_ready); end
    tick();
    in_data = 10'h000;
    for (int k = 0; k < W; k++) begin
      #1;
      n_checks++; if (ser_o !== 1'b1) begin n_errors++; $display("FAIL b2b_ones%0d got %b exp 1", k, ser_o); end
      n_checks++; if (in_ready !== (k == W - 1)) begin n_errors++; $display("FAIL b2b_ready%0d got %b exp %b", k, in_ready, k == W - 1); end
      tick();
    end
    for (int k = 0; k < W; k++) begin
      if (k == W - 1) en = 1'b0;
      #1;
      n_checks++; if ({busy, ser_o} !== 2'b10) begin n_errors++; $display("FAIL b2b_zeros%0d got %b exp 10", k, {busy, ser_o}); end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_underflow();
    logic [9:0] iw = IDLE;
    #1;
    n_checks++; if (unf_cnt !== 16'd0) begin n_errors++; $display("FAIL unf_before got %h exp 0000", unf_cnt); end
    en = 1'b1; in_valid = 1'b0; force_idle = 1'b0;
    tick();
    for (int k = 0; k < W; k++) begin
      if (k == W - 1) en = 1'b0;
      #1;
      n_checks++; if (ser_o !== iw[k]) begin n_errors++; $display("FAIL unf_bit%0d got %b exp %b", k, ser_o, iw[k]); end
      tick();
    end
    #1;
    n_checks++; if (unf_cnt !== 16'd1) begin n_errors++; $display("FAIL unf_after got %h exp 0001", unf_cnt); end
  endtask

  task automatic test_saturation();
    s_clr = 1'b0; s_en = 1'b1;
    for (int n = 1; n <= 65540; n++) begin
      tick();
      if (n == 1 || n == 65534 || n == 65535 || n == 65540) begin
        #1;
        n_checks++;
        if (s_unf !== ((n > 65535) ? 16'hFFFF : 16'(n))) begin
          n_errors++; $display("FAIL sat_n%0d got %h exp %h", n, s_unf, (n > 65535) ? 16'hFFFF : 16'(n));
        end
      end
    end
    s_clr = 1'b1; tick(); #1;
    n_checks++; if (s_unf !== 16'd0) begin n_errors++; $display("FAIL sat_clr got %h exp 0000", s_unf); end
    s_clr = 1'b0; tick(); #1;
    n_checks++; if (s_unf !== 16'd1) begin n_errors++; $display("FAIL sat_reinc got %h exp 0001", s_unf); end
    s_en = 1'b0; tick();
  endtask

  task automatic test_en_drop();
    logic [9:0] w, w2;
    w = 10'($urandom); w2 = 10'($urandom);
    en = 1'b1; in_valid = 1'b1; in_data = w;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < W; k++) begin
      if (k == 3) en = 1'b0;
      #1;
      n_checks++; if ({busy, ser_o} !== {1'b1, w[k]}) begin n_errors++; $display("FAIL drop_bit%0d got %b exp %b", k, {busy, ser_o}, {1'b1, w[k]}); end
      tick();
    end
    #1;
    n_checks++; if ({busy, ser_o} !== 2'b00) begin n_errors++; $display("FAIL drop_off got %b exp 00", {busy, ser_o}); end
    tick();
    en = 1'b1; in_valid = 1'b1; in_data = w2;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL drop_reload got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < W; k++) begin
      if (k == W - 1) en = 1'b0;
      #1;
      n_checks++; if ({word_sync, ser_o} !== {k == 0, w2[k]}) begin n_errors++; $display("FAIL drop_w2_%0d got %b exp %b", k, {word_sync, ser_o}, {k == 0, w2[k]}); end
      tick();
    end
  endtask

  task automatic test_inv();
    en = 1'b1; inv = 1'b0; in_valid = 1'b1; in_data = 10'h001;
    tick();
    for (int k = 0; k < W; k++) begin
      if (k == 4) inv = 1'b1;
      #1;
      n_checks++; if (ser_o !== (k == 0)) begin n_errors++; $display("FAIL inv_old%0d got %b exp %b", k, ser_o, k == 0); end
      tick();
    end
    for (int k = 0; k < W; k++) begin
      if (k == W - 1) en = 1'b0;
      #1;
      n_checks++; if (ser_o !== (k != 0)) begin n_errors++; $display("FAIL inv_new%0d got %b exp %b", k, ser_o, k != 0); end
      tick();
    end
    inv = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [9:0] w  = 10'($urandom);
    logic [9:0] iw = IDLE;
    en = 1'b1; in_valid = 1'b1; in_data = w;
    tick();
    for (int k = 0; k <= 5; k++) begin
      #1;
      n_checks++; if (ser_o !== w[k]) begin n_errors++; $display("FAIL rstmid_bit%0d got %b exp %b", k, ser_o, w[k]); end
      if (k == 5) rst = 1'b1;
      tick();
    end
    rst = 1'b0; en = 1'b0;
    #1;
    n_checks++; if ({ser_o, busy, unf_cnt} !== 18'd0) begin n_errors++; $display("FAIL rstmid_after got %b/%b/%h exp 0/0/0000", ser_o, busy, unf_cnt); end
    en = 1'b1; in_valid = 1'b0;
    tick();
    in_valid = 1'b1; force_idle = 1'b1;
    for (int k = 0; k < W; k++) begin
      #1;
      if (k == W - 1) begin
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL force_ready got %b exp 0", in_ready); end
      end
      tick();
    end
    for (int k = 0; k < W; k++) begin
      if (k == W - 1) en = 1'b0;
      #1;
      n_checks++; if ({ser_o, unf_cnt} !== {iw[k], 16'd1}) begin n_errors++; $display("FAIL force_bit%0d got %b/%h exp %b/0001", k, ser_o, unf_cnt, iw[k]); end
      tick();
    end
    force_idle = 1'b0;
  endtask

  task automatic test_random();
    logic [19:0] got, exp;
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 199) == 0);
      en         = ($urandom_range(0, 9) != 0);
      inv        = ($urandom_range(0, 7) == 0) ? ~inv : inv;
      force_idle = ($urandom_range(0, 7) == 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      in_data    = 10'($urandom);
      unf_clr    = ($urandom_range(0, 49) == 0);
      model_eval();
      #1;
      got = {ser_o, word_sync, busy, in_ready, unf_cnt};
      exp = {e_ser, e_sync, e_busy, e_ready, m_unf};
      n_checks++; if (got !== exp) begin n_errors++; $display("FAIL rand_c%0d got %h exp %h", c, got, exp); end
      tick();
    end
    rst = 1'b0; unf_clr = 1'b0; en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; inv = 1'b0; force_idle = 1'b0; in_valid = 1'b0;
    in_data = '0; unf_clr = 1'b0;
    s_rst = 1'b1; s_en = 1'b0; s_clr = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_underflow();
    test_en_drop();
    test_inv();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
